// File: rtl/matrix_ls_row_sequencer_if.sv
// Command, scratchpad-request and completion signals of the matrix load/store row sequencer.
// master = command issuer / scratchpad side, slave = the sequencer.
interface matrix_ls_row_sequencer_if #(
  parameter int ROWS   = 4,
  parameter int WORD_W = 32,
  parameter int MREG_W = 4
);
  localparam int ROW_W = $clog2(ROWS);

  // command from the load/store dispatch stage
  logic              start;
  logic              is_store;
  logic [WORD_W-1:0] base_addr;
  logic [WORD_W-1:0] stride;
  logic [MREG_W-1:0] rd;
  logic              busy;

  // per-row scratchpad request and its completion
  logic              req_valid;
  logic              req_write;
  logic [WORD_W-1:0] req_addr;
  logic [ROW_W-1:0]  req_row;
  logic              req_ready;
  logic              mhit;

  // completion towards writeback
  logic              done;
  logic [MREG_W-1:0] done_rd;

  modport master (
    output start, is_store, base_addr, stride, rd, req_ready, mhit,
    input  busy, req_valid, req_write, req_addr, req_row, done, done_rd
  );

  modport slave (
    input  start, is_store, base_addr, stride, rd, req_ready, mhit,
    output busy, req_valid, req_write, req_addr, req_row, done, done_rd
  );
endinterface

// File: rtl/matrix_ls_row_sequencer.sv
// Splits one matrix load/store command into ROWS strided scratchpad row requests.
// Optional MATRIX_LS_PERF_EN adds the perf_wait_cycles counter output.
module matrix_ls_row_sequencer #(
  parameter int ROWS   = 4,
  parameter int WORD_W = 32,
  parameter int MREG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     freeze,
  matrix_ls_row_sequencer_if.slave ls
`ifdef MATRIX_LS_PERF_EN
  , output logic [15:0]            perf_wait_cycles
`endif
);
  localparam int ROW_W = $clog2(ROWS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_reg,  state_next;
  logic [ROW_W-1:0]  row_reg,    row_next;
  logic [WORD_W-1:0] addr_reg,   addr_next;
  logic [WORD_W-1:0] stride_reg, stride_next;
  logic              write_reg,  write_next;
  logic [MREG_W-1:0] rd_reg,     rd_next;
  logic              pend_reg,   pend_next;
  logic              start_accept;
  logic              hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      row_reg    <= '0;
      addr_reg   <= '0;
      stride_reg <= '0;
      write_reg  <= 1'b0;
      rd_reg     <= '0;
      pend_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      row_reg    <= row_next;
      addr_reg   <= addr_next;
      stride_reg <= stride_next;
      write_reg  <= write_next;
      rd_reg     <= rd_next;
      pend_reg   <= pend_next;
    end
  end

  // Priority: flush, then freeze, then normal sequencing.
  always_comb begin
    state_next   = state_reg;
    row_next     = row_reg;
    addr_next    = addr_reg;
    stride_next  = stride_reg;
    write_next   = write_reg;
    rd_next      = rd_reg;
    pend_next    = pend_reg;
    start_accept = 1'b0;
    hit          = ls.mhit | pend_reg;

    if (flush) begin
      state_next = IDLE;
      pend_next  = 1'b0;
    end else if (freeze) begin
      // a hit seen while frozen is remembered and consumed once unfrozen
      if ((state_reg == WAIT) && ls.mhit) begin
        pend_next = 1'b1;
      end
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (ls.start) begin
            start_accept = 1'b1;
            addr_next    = ls.base_addr;
            stride_next  = ls.stride;
            write_next   = ls.is_store;
            rd_next      = ls.rd;
            row_next     = '0;
            state_next   = ISSUE;
          end
        end
        ISSUE: begin
          if (ls.req_ready) begin
            state_next = WAIT;
          end
        end
        WAIT: begin
          if (hit) begin
            pend_next = 1'b0;
            if (row_reg == LAST_ROW) begin
              state_next = DONE;
            end else begin
              row_next   = row_reg + 1'b1;
              addr_next  = addr_reg + stride_reg;
              state_next = ISSUE;
            end
          end
        end
        DONE: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Valid and done are masked combinationally so a frozen cycle never handshakes.
  assign ls.busy      = (state_reg != IDLE);
  assign ls.req_valid = (state_reg == ISSUE) && !freeze;
  assign ls.req_write = write_reg;
  assign ls.req_addr  = addr_reg;
  assign ls.req_row   = row_reg;
  assign ls.done      = (state_reg == DONE) && !freeze;
  assign ls.done_rd   = ls.done ? rd_reg : '0;

`ifdef MATRIX_LS_PERF_EN
  logic [15:0] perf_reg;
  logic        perf_inc;

  assign perf_inc = (state_reg == WAIT) || (freeze && (state_reg != IDLE));

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_reg <= '0;
    end else if (start_accept) begin
      perf_reg <= '0;
    end else if (perf_inc && (perf_reg != 16'hFFFF)) begin
      perf_reg <= perf_reg + 16'd1;
    end
  end

  assign perf_wait_cycles = perf_reg;
`endif
endmodule

// File: tb/tb_matrix_ls_row_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a row-level behavioural model.
module tb_matrix_ls_row_sequencer;
  localparam int ROWS   = 4;
  localparam int WORD_W = 32;
  localparam int MREG_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic freeze = 1'b0;
  always #5 clk = ~clk;

  matrix_ls_row_sequencer_if #(.ROWS(ROWS), .WORD_W(WORD_W), .MREG_W(MREG_W)) bus ();

`ifdef MATRIX_LS_PERF_EN
  logic [15:0] perf_wait_cycles;
`endif

  matrix_ls_row_sequencer #(.ROWS(ROWS), .WORD_W(WORD_W), .MREG_W(MREG_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .freeze (freeze),
    .ls     (bus)
`ifdef MATRIX_LS_PERF_EN
    , .perf_wait_cycles (perf_wait_cycles)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] row_addr(input logic [31:0] b, input logic [31:0] s, input int r);
    return b + s * 32'(r);
  endfunction

  // Model: a command is either issuing row m_row, waiting for its hit, or owing a done.
  bit          chk_en = 1'b0;
  bit          m_in_cmd = 1'b0, m_sent = 1'b0, m_done_due = 1'b0, m_pend = 1'b0;
  bit          m_fields_ok = 1'b0, m_write = 1'b0;
  int          m_row = 0;
  logic [31:0] m_base = '0, m_stride = '0;
  logic [3:0]  m_rd = '0;
  int          m_perf = 0;
  logic        m_busy, m_inc;

  assign m_busy = m_in_cmd | m_done_due;
  assign m_inc  = (m_in_cmd & m_sent) | (freeze & m_busy);

  always @(posedge clk) begin
    if (rst) begin
      m_in_cmd <= 1'b0; m_sent <= 1'b0; m_done_due <= 1'b0; m_pend <= 1'b0;
      m_fields_ok <= 1'b1; m_write <= 1'b0; m_row <= 0;
      m_base <= '0; m_stride <= '0; m_rd <= '0; m_perf <= 0; chk_en <= 1'b1;
    end else begin
      if (m_inc && m_perf < 65535) m_perf <= m_perf + 1;
      if (flush) begin
        m_in_cmd <= 1'b0; m_sent <= 1'b0; m_done_due <= 1'b0; m_pend <= 1'b0; m_fields_ok <= 1'b0;
      end else if (freeze) begin
        if (m_in_cmd && m_sent && bus.mhit) m_pend <= 1'b1;
      end else if (m_done_due) begin
        m_done_due <= 1'b0;
      end else if (!m_in_cmd) begin
        if (bus.start) begin
          m_in_cmd <= 1'b1; m_sent <= 1'b0; m_row <= 0; m_perf <= 0; m_fields_ok <= 1'b1;
          m_base <= bus.base_addr; m_stride <= bus.stride; m_write <= bus.is_store; m_rd <= bus.rd;
        end
      end else if (!m_sent) begin
        if (bus.req_ready) m_sent <= 1'b1;
      end else if (bus.mhit || m_pend) begin
        m_pend <= 1'b0;
        m_sent <= 1'b0;
        if (m_row == ROWS - 1) begin
          m_in_cmd <= 1'b0;
          m_done_due <= 1'b1;
        end else begin
          m_row <= m_row + 1;
        end
      end
    end
  end

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  logic [31:0] hs_addr[$];
  int          hs_row[$];
  int          hs_edge[$];
  bit          hs_wr[$];
  int          done_cnt = 0;
  int          last_done_edge = 0;
  int          last_done_rd = 0;

  // Compare process: 3 time units after the falling edge, inputs and outputs are settled.
  always @(negedge clk) begin
    #3;
    if (chk_en) begin
      chk("busy", bus.busy, m_busy);
      chk("req_valid", bus.req_valid, m_in_cmd && !m_sent && !freeze);
      chk("done", bus.done, m_done_due && !freeze);
      if (m_done_due && !freeze) chk("done_rd", bus.done_rd, m_rd);
      if (m_fields_ok) begin
        chk("req_addr", bus.req_addr, row_addr(m_base, m_stride, m_row));
        chk("req_row", bus.req_row, m_row);
        chk("req_write", bus.req_write, m_write);
      end
`ifdef MATRIX_LS_PERF_EN
      chk("perf_wait_cycles", perf_wait_cycles, m_perf);
`endif
    end
    if (bus.req_valid && bus.req_ready && !rst && !flush) begin
      hs_addr.push_back(bus.req_addr);
      hs_row.push_back(int'(bus.req_row));
      hs_edge.push_back(edge_cnt);
      hs_wr.push_back(bus.req_write);
    end
    if (bus.done && !rst) begin
      done_cnt++;
      last_done_edge = edge_cnt;
      last_done_rd = int'(bus.done_rd);
      $display("done rd=%0d edge=%0d", bus.done_rd, edge_cnt);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  int start_mark = 0;

  task automatic clear_log();
    hs_addr.delete(); hs_row.delete(); hs_edge.delete(); hs_wr.delete();
    done_cnt = 0;
  endtask

  // mode 0 plain, 1 backpressure, 2 freeze, 3 flush+restart, 4 start-while-busy, 5 reset mid-command
  task automatic run_cmd(input logic [31:0] base, input logic [31:0] stride, input bit st,
                         input logic [3:0] rd, input int mode, input int ncyc);
    clear_log();
    for (int j = 0; j < ncyc; j++) begin
      tick();
      rst = 1'b0; flush = 1'b0; freeze = 1'b0;
      bus.start = (j == 0); bus.base_addr = base; bus.stride = stride;
      bus.is_store = st; bus.rd = rd; bus.req_ready = 1'b1; bus.mhit = 1'b1;
      if (j == 0) start_mark = edge_cnt;
      case (mode)
        1: if (j >= 3 && j <= 7) bus.req_ready = 1'b0;
        2: begin
          if (j >= 6 && j <= 9) bus.mhit = (j == 7);
          freeze = (j >= 6 && j <= 8);
        end
        3: begin
          if (j == 4) begin flush = 1'b1; bus.start = 1'b1; end
          if (j == 6) begin
            bus.start = 1'b1; bus.base_addr = 32'h2000; bus.stride = 32'h10; bus.rd = 4'd5;
            start_mark = edge_cnt;
            hs_addr.delete(); hs_row.delete(); hs_edge.delete(); hs_wr.delete();
          end
        end
        4: if (j == 1) begin bus.start = 1'b1; bus.base_addr = 32'hDEAD0000; end
        5: if (j == 2) rst = 1'b1;
        default: ;
      endcase
      if (mode == 3 && j == 5) begin
        #3;
        chk("flush_idle_busy", bus.busy, 0);
        chk("flush_idle_valid", bus.req_valid, 0);
      end
      if (mode == 5 && j == 3) begin
        #3;
        chk("rst_busy", bus.busy, 0);
        chk("rst_req_valid", bus.req_valid, 0);
        chk("rst_req_write", bus.req_write, 0);
        chk("rst_req_addr", bus.req_addr, 0);
        chk("rst_req_row", bus.req_row, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_done_rd", bus.done_rd, 0);
`ifdef MATRIX_LS_PERF_EN
        chk("rst_perf", perf_wait_cycles, 0);
`endif
      end
    end
    tick();
    bus.start = 1'b0; bus.mhit = 1'b0; bus.req_ready = 1'b0;
    #3;
  endtask

  task automatic chk_seq(input string name, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [31:0] a3);
    logic [31:0] exp_a[4];
    exp_a[0] = a0; exp_a[1] = a1; exp_a[2] = a2; exp_a[3] = a3;
    chk({name, "_hs_count"}, hs_addr.size(), 4);
    for (int i = 0; i < 4 && i < hs_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", name, i), hs_addr[i], exp_a[i]);
      chk($sformatf("%s_row%0d", name, i), hs_row[i], i);
    end
    $display("test %s handshakes=%0d dones=%0d", name, hs_addr.size(), done_cnt);
  endtask

  initial begin
    bus.start = 1'b0; bus.is_store = 1'b0; bus.base_addr = '0; bus.stride = '0; bus.rd = '0;
    bus.req_ready = 1'b0; bus.mhit = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #3;
    chk("reset_busy", bus.busy, 0);
    chk("reset_req_valid", bus.req_valid, 0);
    chk("reset_req_addr", bus.req_addr, 0);
    chk("reset_done", bus.done, 0);

    run_cmd(32'h1000, 32'h40, 1'b0, 4'd3, 0, 14);
    chk_seq("basic", 32'h1000, 32'h1040, 32'h1080, 32'h10C0);
    chk("basic_dones", done_cnt, 1);
    chk("basic_latency", last_done_edge - start_mark - 1, 2 * ROWS);
    chk("basic_done_rd", last_done_rd, 3);
    chk("basic_busy_after", bus.busy, 0);
`ifdef MATRIX_LS_PERF_EN
    chk("basic_perf", perf_wait_cycles, 4);
`endif

    run_cmd(32'h1000, 32'h40, 1'b0, 4'd3, 1, 20);
    chk_seq("backpressure", 32'h1000, 32'h1040, 32'h1080, 32'h10C0);
    chk("backpressure_latency", last_done_edge - start_mark - 1, 13);
    chk("backpressure_dones", done_cnt, 1);

    run_cmd(32'hFFFFFFC0, 32'h20, 1'b1, 4'd9, 0, 14);
    chk_seq("wrap", 32'hFFFFFFC0, 32'hFFFFFFE0, 32'h0, 32'h20);
    if (hs_wr.size() == 4) chk("wrap_req_write", hs_wr[3], 1);

    run_cmd(32'h4000, 32'h100, 1'b0, 4'd7, 2, 18);
    chk_seq("freeze", 32'h4000, 32'h4100, 32'h4200, 32'h4300);
    chk("freeze_dones", done_cnt, 1);
    chk("freeze_latency", last_done_edge - start_mark - 1, 11);
    if (hs_edge.size() == 4) chk("freeze_row3_issue", hs_edge[3] - start_mark, 10);
`ifdef MATRIX_LS_PERF_EN
    chk("freeze_perf", perf_wait_cycles, 7);
`endif

    run_cmd(32'h3000, 32'h8, 1'b0, 4'd2, 3, 20);
    chk_seq("flush_restart", 32'h2000, 32'h2010, 32'h2020, 32'h2030);
    chk("flush_dones", done_cnt, 1);
    chk("flush_done_rd", last_done_rd, 5);
    chk("flush_latency", last_done_edge - start_mark - 1, 2 * ROWS);

    run_cmd(32'h5000, 32'h0, 1'b0, 4'd1, 4, 14);
    chk_seq("busy_start", 32'h5000, 32'h5000, 32'h5000, 32'h5000);
    chk("busy_start_dones", done_cnt, 1);

    run_cmd(32'h6000, 32'h40, 1'b1, 4'd12, 5, 14);
    chk("reset_mid_dones", done_cnt, 0);

    for (int c = 0; c < 4000; c++) begin
      tick();
      rst = ($urandom_range(0, 599) == 0);
      flush = ($urandom_range(0, 39) == 0);
      freeze = ($urandom_range(0, 7) == 0);
      bus.start = ($urandom_range(0, 3) == 0);
      bus.base_addr = $urandom();
      bus.stride = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom();
      bus.is_store = $urandom_range(0, 1);
      bus.rd = 4'($urandom_range(0, 15));
      bus.req_ready = ($urandom_range(0, 2) != 0);
      bus.mhit = $urandom_range(0, 1);
    end
    tick();
    rst = 1'b0; flush = 1'b0; freeze = 1'b0; bus.start = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/matrix_ls_row_sequencer.md
Name: matrix_ls_row_sequencer

Overview:
- Sits directly downstream of the matrix load/store dispatch interface.
- Accepts one matrix load/store command (base address, stride, direction, destination matrix register) and breaks it into ROWS per-row scratchpad requests at base, base+stride, base+2*stride, ...
- Issues one row at a time, waits for the scratchpad hit (mhit) before advancing, and reports completion to writeback.
- Obeys pipeline flush (abort) and freeze (stall).

Parameters:
- ROWS, 4, rows per matrix; must be ≥2 and a power of two.
- WORD_W, 32, address/stride width (word_t).
- MREG_W, 4, matrix register id width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- flush  in  1  abort current command.
- freeze  in  1  stall all state.
- start  in  1  command valid, one-cycle pulse; sampled only in IDLE.
- is_store  in  1  1 = store, 0 = load; latched on accepted start.
- base_addr  in  WORD_W  matrix base address; latched on start.
- stride  in  WORD_W  byte stride between rows; latched on start.
- rd  in  MREG_W  destination/source matrix register; latched on start.
- busy  out  1  high in any state other than IDLE.
- req_valid  out  1  row request valid to scratchpad.
- req_write  out  1  latched is_store.
- req_addr  out  WORD_W  current row address.
- req_row  out  $clog2(ROWS)  current row index.
- req_ready  in  1  scratchpad accepts the request.
- mhit  in  1  scratchpad completed the outstanding row.
- done  out  1  one-cycle completion pulse.
- done_rd  out  MREG_W  latched rd; valid only while done=1.

Behaviour:
- Reset (RST=1 at a clock edge):
  - State goes to IDLE.
  - busy=0, req_valid=0, req_write=0, req_addr=0, req_row=0, done=0, done_rd=0.
  - Pending-hit flag cleared.
  - Reset mid-command abandons it with no done.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: start=1 and flush=0 → latch inputs, req_addr←base_addr, row←0, go to ISSUE.
- ISSUE:
  - req_valid=1.
  - req_valid & req_ready at the clock edge → go to WAIT; req_valid drops the next cycle.
  - Request fields stay stable until accepted.
- WAIT:
  - mhit=1 (or pending-hit set) on a row < ROWS-1 → row+1, req_addr←req_addr+stride (modulo 2^WORD_W, wrap-around permitted, no error), go to ISSUE.
  - The same event on row ROWS-1 → go to DONE.
  - mhit outside WAIT is ignored.
- DONE:
  - done=1 and done_rd=rd for exactly one cycle.
  - Then IDLE; busy stays high through DONE.
- Minimum latency, start to done pulse, with req_ready and mhit returned immediately: 1 + 2*ROWS cycles. Start accepted at edge 0; done high in the cycle after edge 2*ROWS.
- freeze=1 (and no flush):
  - All registers hold; req_valid forced 0 and done forced 0.
  - A ready at that edge is not a handshake.
  - An mhit arriving in WAIT during freeze sets pending-hit; it is consumed on the first unfrozen WAIT edge.
  - A done held in DONE is emitted once freeze drops.
  - start during freeze is ignored.
- flush=1:
  - Highest priority after RST; state goes to IDLE, pending-hit cleared, no done.
  - Outputs take the IDLE values next cycle; latched address/rd retain their values but are don't-care.
  - flush and start in the same cycle: start dropped.
  - flush and freeze together: flush wins.
- start while busy: ignored, no queueing.
- stride=0 is legal: all rows use the same address.

Optional Feature:
- MATRIX_LS_PERF_EN defined:
  - Adds output perf_wait_cycles [15:0], counting cycles spent in WAIT or frozen while busy for the current command.
  - Saturates at 16'hFFFF.
  - Cleared on accepted start and on RST; holds its value after done until the next start.
- Not defined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Basic load: start, base=0x1000, stride=0x40, is_store=0, rd=3; req_ready and mhit tied to immediate response.
  → req_addr sequence 0x1000, 0x1040, 0x1080, 0x10C0; req_row 0..3; done pulse at cycle 9 with done_rd=3; busy 0 afterwards.
- Backpressure: req_ready held low 5 cycles on row 1.
  → req_valid/req_addr=0x1040 stable for all 5 cycles; sequence otherwise unchanged; done 5 cycles later.
- Wrap and store: base=0xFFFFFFC0, stride=0x20, is_store=1.
  → req_write=1; addresses 0xFFFFFFC0, 0xFFFFFFE0, 0x00000000, 0x00000020.
- Freeze with hit: freeze high 3 cycles in WAIT on row 2, mhit pulsed during freeze.
  → no request issued while frozen; row 3 issued on the first cycle after unfreeze; exactly one done.
- Flush mid-command: flush during WAIT on row 1, start in the same cycle.
  → IDLE next cycle, no done, start ignored; a new start two cycles later runs a full 4-row command correctly.
- Reset mid-command and start-while-busy: second start during ISSUE ignored (only 4 requests); RST in WAIT → all outputs zero next cycle; with MATRIX_LS_PERF_EN, perf_wait_cycles reads 0.
